// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for an asynchronous level input; resets to 1 (idle line).
module rx_synchronizer (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB-first, single-cycle done pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned SB_TICK   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 s_tick,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_err
);

    localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int unsigned NW = $clog2(DATA_BITS);

    rx_state_t            state;
    logic [SW-1:0]        s_cnt;
    logic [NW-1:0]        n_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;

    rx_synchronizer u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame sequencer; everything except the start-edge detect waits for s_tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            shift        <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_cnt == SW'(MID_SAMPLE)) begin
                            s_cnt <= '0;
                            n_cnt <= '0;
                            // A line that has gone high again by mid start bit was a glitch.
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_cnt == SW'(OVERSAMPLE - 1)) begin
                            s_cnt <= '0;
                            shift <= {rx_s, shift[DATA_BITS-1:1]};
                            if (n_cnt == NW'(DATA_BITS - 1)) begin
                                state <= STOP;
                            end else begin
                                n_cnt <= n_cnt + NW'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_cnt == SW'(SB_TICK - 1)) begin
                            dout         <= shift;
                            frame_err    <= ~rx_s;
                            rx_done_tick <= 1'b1;
                            state        <= IDLE;
                            s_cnt        <= '0;
                        end else begin
                            s_cnt <= s_cnt + SW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx; expected frames come from what the bench transmits.
module tb_uart_rx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       rx2   = 1'b1;
    logic       s_tick = 1'b0;
    logic [1:0] tdiv  = 2'd0;
    int         cyc   = 0;

    logic [7:0] dout1;
    logic       done1, fe1;
    logic [6:0] dout2;
    logic       done2, fe2;

    uart_rx #(.DATA_BITS(8), .SB_TICK(16)) dut1 (
        .clock(clock), .reset(reset), .rx(rx), .s_tick(s_tick),
        .dout(dout1), .rx_done_tick(done1), .frame_err(fe1)
    );

    uart_rx #(.DATA_BITS(7), .SB_TICK(32)) dut2 (
        .clock(clock), .reset(reset), .rx(rx2), .s_tick(s_tick),
        .dout(dout2), .rx_done_tick(done2), .frame_err(fe2)
    );

    always #5 clock = ~clock;

    // One tick every 4 clocks: one bit period = 64 clocks.
    always @(posedge clock) begin
        cyc    <= cyc + 1;
        tdiv   <= tdiv + 2'd1;
        s_tick <= (tdiv == 2'd3);
    end

    typedef struct {
        logic [7:0] d;
        logic       fe;
        int         t;
    } pulse_t;

    typedef struct {
        logic [7:0] d;
        logic       fe;
    } exp_t;

    pulse_t obs1[$];
    pulse_t obs2[$];
    exp_t   exp1[$];

    always @(negedge clock) begin
        if (done1 === 1'b1) obs1.push_back('{dout1, fe1, cyc});
        if (done2 === 1'b1) obs2.push_back('{8'(dout2), fe2, cyc});
    end

    int checks = 0;
    int errors = 0;
    int idx1 = 0;
    int last_start = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input bit line2, input int n);
        if (line2) rx2 = v;
        else       rx  = v;
        repeat (n) @(negedge clock);
    endtask

    // Transmit one frame; a bad stop bit is low long enough to be sampled, then released.
    task automatic send(input logic [7:0] d, input int nbits, input int nstop,
                        input bit bad, input bit line2);
        last_start = cyc;
        drive(1'b0, line2, 64);
        for (int i = 0; i < nbits; i++) drive(d[i], line2, 64);
        if (bad) begin
            drive(1'b0, line2, 48);
            drive(1'b1, line2, 16 + (nstop - 1) * 64);
        end else begin
            drive(1'b1, line2, nstop * 64);
        end
        if (!line2) exp1.push_back('{d, bad});
    endtask

    // Compare every pulse seen since the last call against the frames sent since then.
    task automatic verify1(input string tag);
        int n;
        n = obs1.size() - idx1;
        chk({tag, " pulse count"}, 32'(n), 32'(exp1.size()));
        for (int k = 0; k < n && k < exp1.size(); k++) begin
            chk({tag, " dout"}, 32'(obs1[idx1 + k].d), 32'(exp1[k].d));
            chk({tag, " frame_err"}, 32'(obs1[idx1 + k].fe), 32'(exp1[k].fe));
        end
        idx1 += n;
        exp1.delete();
    endtask

    initial begin
        int lat;
        int gap;
        bit bad;
        logic [7:0] d;
        logic [7:0] c3;

        repeat (3) @(negedge clock);
        chk("reset dout", 32'(dout1), 32'h0);
        chk("reset done", 32'(done1), 32'h0);
        chk("reset frame_err", 32'(fe1), 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clock);

        // Single frame with latency check
        send(8'hA5, 8, 1, 1'b0, 1'b0);
        repeat (8) @(negedge clock);
        lat = (obs1.size() > idx1) ? obs1[idx1].t - last_start : -1;
        chk("a5 latency 604..616", 32'(lat >= 604 && lat <= 616), 32'h1);
        verify1("a5");

        // Back-to-back, no idle gap
        send(8'h3C, 8, 1, 1'b0, 1'b0);
        send(8'hFF, 8, 1, 1'b0, 1'b0);
        repeat (8) @(negedge clock);
        verify1("b2b");

        // Start glitch shorter than half a bit
        drive(1'b0, 1'b0, 12);
        drive(1'b1, 1'b0, 100);
        verify1("glitch");
        chk("glitch dout held", 32'(dout1), 32'hFF);

        // Framing error, then a clean frame
        send(8'h55, 8, 1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 64);
        send(8'h01, 8, 1, 1'b0, 1'b0);
        repeat (8) @(negedge clock);
        verify1("ferr");

        // Reset during data bit 4
        c3 = 8'hC3;
        drive(1'b0, 1'b0, 64);
        for (int i = 0; i < 4; i++) drive(c3[i], 1'b0, 64);
        drive(c3[4], 1'b0, 32);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("midreset dout", 32'(dout1), 32'h0);
        chk("midreset done", 32'(done1), 32'h0);
        chk("midreset frame_err", 32'(fe1), 32'h0);
        rx = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 1'b0, 100);
        send(8'h7E, 8, 1, 1'b0, 1'b0);
        repeat (8) @(negedge clock);
        verify1("after reset");

        // 7 data bits, 2 stop bits
        send(8'h5A, 7, 2, 1'b0, 1'b1);
        repeat (8) @(negedge clock);
        chk("db7 pulse count", 32'(obs2.size()), 32'h1);
        if (obs2.size() > 0) begin
            chk("db7 dout", 32'(obs2[0].d), 32'h5A);
            chk("db7 frame_err", 32'(obs2[0].fe), 32'h0);
            lat = obs2[0].t - last_start;
            chk("db7 latency 604..616", 32'(lat >= 604 && lat <= 616), 32'h1);
        end

        // Random bytes, random idle gaps, occasional bad stop bit
        for (int f = 0; f < 10; f++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(0, 80);
            drive(1'b1, 1'b0, gap);
            send(d, 8, 1, bad, 1'b0);
            if (bad) drive(1'b1, 1'b0, 64);
        end
        repeat (8) @(negedge clock);
        verify1("random");
        chk("dut2 no extra pulses", 32'(obs2.size()), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
